// File: rtl/mult_div_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// mduop_t is the opcode handed over by decode alongside the forwarded operands.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mduop_t;

  function automatic logic isSignedOp(input mduop_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic isDivOp(input mduop_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift register serves as product (MULT) or remainder:quotient (DIV).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  mduop_t           op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  input  logic             wen_hi,
  input  logic             wen_lo,
  input  logic [WIDTH-1:0] wdat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   aRaw_q, aRaw_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // Magnitudes are unsigned, so |INT_MIN| = 2^(WIDTH-1) is represented exactly.
  assign aNeg = isSignedOp(op) & A[WIDTH-1];
  assign bNeg = isSignedOp(op) & B[WIDTH-1];
  assign aMag = aNeg ? (WIDTH'(0) - A) : A;
  assign bMag = bNeg ? (WIDTH'(0) - B) : B;

  assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign divShift = acc_q[2*WIDTH-1:WIDTH-1];
  assign divDiff  = divShift - {1'b0, opnd_q};
  assign divFits  = ~divDiff[WIDTH];

  assign prodFix = negRes_q ? (-acc_q) : acc_q;
  assign quotFix = negRes_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign remFix  = negRem_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    aRaw_d    = aRaw_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wen_hi) hi_d = wdat;
        if (wen_lo) lo_d = wdat;
        if (start && !flush) begin
          state_d   = S_CALC;
          cnt_d     = CW'(WIDTH - 1);
          acc_d     = {{WIDTH{1'b0}}, aMag};
          opnd_d    = bMag;
          aRaw_d    = A;
          isDiv_d   = isDivOp(op);
          negRes_d  = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = (B == '0);
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (isDiv_q) begin
            acc_d = divFits ? {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                            : {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          // Divide by zero returns a fixed pattern rather than trapping.
          if (isDiv_q && divZero_q) begin
            hi_d = aRaw_q;
            lo_d = '1;
          end else if (isDiv_q) begin
            hi_d = remFix;
            lo_d = quotFix;
          end else begin
            {hi_d, lo_d} = prodFix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      aRaw_q    <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      aRaw_q    <= aRaw_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, multi-cycle
// corner sequences (flush, start/MTHI while busy, reset mid-op) and random ops.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST, start, flush, wen_hi, wen_lo;
  mduop_t       op;
  logic [W-1:0] A, B, wdat;
  logic         busy, done;
  logic [W-1:0] HI, LO;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    mduop_t     op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .wen_hi(wen_hi), .wen_lo(wen_lo), .wdat(wdat),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Launch one op and wait (bounded) for done; lat counts edges from the sampling edge.
  task automatic applyStimulus(input mduop_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int lat);
    @(negedge CLK);
    op = o; A = a; B = b; start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      if (done) begin
        lat = i;
        checkOutput("doneWithoutBusy", {63'd0, busy}, 64'd0);
        break;
      end
    end
  endtask

  function automatic logic [63:0] refModel(input mduop_t o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    case (o)
      MDU_MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  initial begin
    int      lat;
    int      cyc;
    logic    sawDone;
    mduop_t  ro;
    logic [W-1:0] ra, rb;

    RST = 1'b1; start = 1'b0; flush = 1'b0; wen_hi = 1'b0; wen_lo = 1'b0;
    op = MDU_MULT; A = '0; B = '0; wdat = '0;

    vecs.push_back('{"multuMax",     MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE});
    vecs.push_back('{"multNeg",      MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"divNeg",       MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu100by7",   MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"divByZero",    MDU_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    vecs.push_back('{"divMinByM1",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{"multMinMin",   MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0});
    vecs.push_back('{"multuCarry",   MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0});
    vecs.push_back('{"divPosByNeg",  MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{"divuByZero",   MDU_DIVU,  32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"divNegByZero", MDU_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF});
    vecs.push_back('{"multM1M1",     MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});
    vecs.push_back('{"divuMinBy3",   MDU_DIVU,  32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA});
    vecs.push_back('{"multuMaxMax",  MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});

    tick(3);
    RST = 1'b0;
    checkOutput("resetBusy", {63'd0, busy}, 64'd0);
    checkOutput("resetDone", {63'd0, done}, 64'd0);
    checkOutput("resetHi", {32'd0, HI}, 64'd0);
    checkOutput("resetLo", {32'd0, LO}, 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      checkOutput({vecs[i].name, "Latency"}, 64'(lat), 64'd34);
      checkOutput({vecs[i].name, "Hi"}, {32'd0, HI}, {32'd0, vecs[i].expHi});
      checkOutput({vecs[i].name, "Lo"}, {32'd0, LO}, {32'd0, vecs[i].expLo});
      tick(1);
      checkOutput({vecs[i].name, "DonePulse"}, {63'd0, done}, 64'd0);
    end

    // MTHI/MTLO in IDLE land on the next edge.
    wen_hi = 1'b1; wdat = 32'h1111_2222;
    tick(1);
    wen_hi = 1'b0; wen_lo = 1'b1; wdat = 32'h3333_4444;
    tick(1);
    wen_lo = 1'b0;
    checkOutput("mthiIdle", {32'd0, HI}, 64'h1111_2222);
    checkOutput("mtloIdle", {32'd0, LO}, 64'h3333_4444);

    // Flush mid-CALC: busy drops next cycle, HI/LO untouched, no done.
    op = MDU_MULT; A = 32'd3; B = 32'd4; start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("flushBusyBefore", {63'd0, busy}, 64'd1);
    tick(9);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    checkOutput("flushBusyAfter", {63'd0, busy}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done) sawDone = 1'b1;
    end
    checkOutput("flushNoDone", {63'd0, sawDone}, 64'd0);
    checkOutput("flushHiKept", {32'd0, HI}, 64'h1111_2222);
    checkOutput("flushLoKept", {32'd0, LO}, 64'h3333_4444);

    // start together with flush in IDLE is not accepted.
    op = MDU_MULTU; A = 32'd9; B = 32'd9; start = 1'b1; flush = 1'b1;
    tick(1);
    start = 1'b0; flush = 1'b0;
    checkOutput("startFlushIdle", {63'd0, busy}, 64'd0);

    // start and MTHI while busy are both ignored.
    op = MDU_MULTU; A = 32'd3; B = 32'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 1;
    tick(4);
    cyc += 4;
    op = MDU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1; wen_hi = 1'b1; wdat = 32'hDEAD_BEEF;
    tick(1);
    cyc++;
    start = 1'b0; wen_hi = 1'b0;
    while (!done && cyc < 60) begin
      tick(1);
      cyc++;
    end
    checkOutput("busyIgnoreLatency", 64'(cyc), 64'd34);
    checkOutput("busyIgnoreHi", {32'd0, HI}, 64'd0);
    checkOutput("busyIgnoreLo", {32'd0, LO}, 64'd15);
    tick(1);
    checkOutput("busyIgnoreNoRestart", {63'd0, busy}, 64'd0);

    // MTLO and start in the same IDLE cycle: MTLO first, result later.
    op = MDU_MULTU; A = 32'd2; B = 32'd3; start = 1'b1; wen_lo = 1'b1; wdat = 32'h0000_ABCD;
    tick(1);
    start = 1'b0; wen_lo = 1'b0;
    checkOutput("mtStartLoEarly", {32'd0, LO}, 64'h0000_ABCD);
    checkOutput("mtStartBusy", {63'd0, busy}, 64'd1);
    cyc = 1;
    while (!done && cyc < 60) begin
      tick(1);
      cyc++;
    end
    checkOutput("mtStartLatency", 64'(cyc), 64'd34);
    checkOutput("mtStartLoFinal", {32'd0, LO}, 64'd6);
    checkOutput("mtStartHiFinal", {32'd0, HI}, 64'd0);

    // Reset mid-op clears HI/LO and aborts.
    op = MDU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checkOutput("rstMidBusy", {63'd0, busy}, 64'd0);
    checkOutput("rstMidHi", {32'd0, HI}, 64'd0);
    checkOutput("rstMidLo", {32'd0, LO}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (done) sawDone = 1'b1;
    end
    checkOutput("rstMidNoDone", {63'd0, sawDone}, 64'd0);

    // Random operands against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ro = mduop_t'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 15));
      if (i % 8 == 2) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (i % 16 == 3) ra = 32'h8000_0000;
      applyStimulus(ro, ra, rb, lat);
      checkOutput($sformatf("rand%0dLatency", i), 64'(lat), 64'd34);
      checkOutput($sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb), {HI, LO}, refModel(ro, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
